// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   op_code      - 4-bit opcode enum, the same encoding the single-cycle ALU uses.
//   alu_state_t  - controller states for alu_seq.
//   ITER_OPS     - opcodes that can run for more than one cycle (the shifts).
//   is_iter_op() - membership test against ITER_OPS.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_INC = 4'h2,
    OP_DEC = 4'h3,
    OP_ADC = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_SET = 4'h7,
    OP_CLR = 4'h8,
    OP_SL  = 4'h9,
    OP_SR  = 4'hA,
    OP_LD  = 4'hB,
    OP_ST  = 4'hC,
    OP_BZ  = 4'hD,
    OP_BNZ = 4'hE,
    OP_JMP = 4'hF
  } op_code;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  localparam int NUM_ITER_OPS = 2;
  localparam op_code ITER_OPS [NUM_ITER_OPS] = '{OP_SL, OP_SR};

  function automatic logic is_iter_op(input op_code op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_ITER_OPS; i++) begin
      if (op == ITER_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: combinational result and carry for every non-shift opcode.
//   op_i      opcode
//   rs_i      operand s
//   rt_i      operand t
//   carry_i   stored carry, consumed by ADC
//   result_o  WIDTH-bit result
//   carry_o   carry/borrow out (0 for logic and control ops)
// Arithmetic runs at WIDTH+1 bits so the top bit is the carry, or the
// borrow for subtraction.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_code           op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] rs_x;
  logic [WIDTH:0] rt_x;
  logic [WIDTH:0] one_x;
  logic [WIDTH:0] cin_x;
  logic [WIDTH:0] wide;

  assign rs_x  = {1'b0, rs_i};
  assign rt_x  = {1'b0, rt_i};
  assign one_x = {{WIDTH{1'b0}}, 1'b1};
  assign cin_x = {{WIDTH{1'b0}}, carry_i};

  always_comb begin
    wide = '0;
    unique case (op_i)
      OP_ADD:  wide = rt_x + rs_x;
      OP_SUB:  wide = rt_x - rs_x;
      OP_INC:  wide = rt_x + one_x;
      OP_DEC:  wide = rt_x - one_x;
      OP_ADC:  wide = rt_x + cin_x;
      OP_AND:  wide = {1'b0, rs_i & rt_i};
      OP_OR:   wide = {1'b0, rs_i | rt_i};
      OP_SET:  wide = {1'b0, rs_i};
      OP_CLR:  wide = '0;
      // A zero-length shift passes rt through unchanged.
      OP_SL,
      OP_SR:   wide = {1'b0, rt_i};
      default: wide = '0;
    endcase
  end

  assign result_o = wide[WIDTH-1:0];
  assign carry_o  = wide[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with internal carry/zero flags and iterative shifts.
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   start_i   request, accepted only while busy_o=0
//   op_i      opcode (op_code encoding)
//   rs_i      operand s / shift amount
//   rt_i      operand t
//   busy_o    a shift is in progress
//   done_o    one-cycle pulse when result_o/ov_o/z_o update
//   result_o  registered result
//   ov_o      carry/borrow flag; also the carry consumed by ADC
//   z_o       zero flag of result_o
//
// state | meaning
// IDLE  | accepting requests; single-cycle ops finish here
// SHIFT | shifting work_q one bit per cycle, cnt_q bits remaining
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ov_o,
  output logic             z_o
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  alu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_r_q, dir_r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  op_code           op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] comb_result;
  logic             comb_carry;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;

  assign op = op_code'(op_i);

  // Shift amounts above WIDTH clamp to WIDTH; after the compare the value
  // fits in CNT_W bits.
  assign amount = (rs_i > WIDTH_V) ? CNT_MAX : CNT_W'(rs_i);

  alu_seq_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .op_i    (op),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .carry_i (ov_q),
    .result_o(comb_result),
    .carry_o (comb_carry)
  );

  assign shifted = dir_r_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign out_bit = dir_r_q ? work_q[0] : work_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dir_r_d  = dir_r_q;
    result_d = result_q;
    ov_d     = ov_q;
    z_d      = z_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (is_iter_op(op) && (amount != '0)) begin
            state_d = SHIFT;
            work_d  = rt_i;
            cnt_d   = amount;
            dir_r_d = (op == OP_SR);
          end else begin
            // Zero-length shifts land here too; the comb block passes rt
            // through with carry 0.
            result_d = comb_result;
            ov_d     = comb_carry;
            z_d      = (comb_result == '0);
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = IDLE;
          result_d = shifted;
          ov_d     = out_bit;
          z_d      = (shifted == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dir_r_q  <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
      z_q      <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dir_r_q  <= dir_r_d;
      result_q <= result_d;
      ov_q     <= ov_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == SHIFT);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign ov_o     = ov_q;
  assign z_o      = z_q;

endmodule
